// File: rtl/data_memory_bytelane_if.sv
// ---------------------------------------------------------------------------
// data_memory_bytelane_if
//   Request/response bundle between a pipeline MEM stage (or multicycle
//   control FSM) and the data_memory_bytelane storage block.
//
//   Requester -> memory:
//     req_i         access request, accepted when req_i && ready_o
//     we_i          1 = store, 0 = load
//     size_i        00 byte, 01 half, 10 word, 11 reserved (error)
//     unsigned_i    loads only: 1 = zero-extend, 0 = sign-extend
//     address_i     byte address
//     write_data_i  store data (sub-word stores use the low bits)
//   Memory -> requester:
//     ready_o       a request can be accepted this cycle
//     valid_o       one-cycle response strobe
//     data_o        formatted load data; 0 for stores and errors
//     error_o       qualifies valid_o: the access was rejected
// ---------------------------------------------------------------------------
interface data_memory_bytelane_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [1:0]            size_i;
  logic                  unsigned_i;
  logic [DATA_WIDTH-1:0] address_i;
  logic [DATA_WIDTH-1:0] write_data_i;
  logic                  ready_o;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  error_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, address_i, write_data_i,
    input  ready_o, valid_o, data_o, error_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, address_i, write_data_i,
    output ready_o, valid_o, data_o, error_o
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// ---------------------------------------------------------------------------
// data_memory_bytelane
//   Word-organised data RAM with base-address translation, byte/half/word
//   stores through per-lane write enables, sign/zero-extended sub-word
//   loads and a configurable read latency (1..4) behind a req/ready/valid
//   handshake. Misaligned, reserved-size and out-of-range accesses are
//   answered with error_o instead of aliasing into the array.
//
//   Ports:
//     clk    rising-edge clock for all state
//     reset  synchronous, active-low reset (RAM contents are kept)
//     bus    data_memory_bytelane_if.slave request/response bundle
//
//   Timing:
//     store / error accepted at edge T -> valid_o in cycle T+1
//     load accepted at edge T          -> valid_o in cycle T+READ_LATENCY,
//                                         ready_o low for READ_LATENCY-1 cycles
// ---------------------------------------------------------------------------
module data_memory_bytelane #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  data_memory_bytelane_if.slave  bus
);

  localparam int          NUM_LANES = DATA_WIDTH / 8;
  localparam int          AW        = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [31:0] SPAN      = 32'(MEMORY_DEPTH * 4);
  // WAIT is entered with the number of additional wait cycles still to go.
  localparam logic [1:0]  WAIT_INIT = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            cnt_reg, cnt_next;
  logic                  valid_reg, valid_next;
  logic                  error_reg, error_next;
  logic [DATA_WIDTH-1:0] hold_reg, hold_next;
  logic                  show_reg, show_next;

  // Registered RAM read port plus the load attributes captured with it.
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word_reg;
  logic [1:0]            rd_lane_reg;
  logic [1:0]            rd_size_reg;
  logic                  rd_unsigned_reg;

  // ---------------------------------------------------------------------
  // Address decode and request classification
  // ---------------------------------------------------------------------
  logic [31:0]   offset;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          out_of_range, misaligned, reserved_size, req_error;
  logic          ready, accept, store_ok, load_ok, error_acc;

  // Wrap subtraction: addresses below the base become huge offsets and
  // therefore fall into the out-of-range check as well.
  assign offset        = bus.address_i - BASE_ADDR;
  assign lane          = offset[1:0];
  assign word_idx      = offset[AW+1:2];
  assign out_of_range  = (offset >= SPAN);
  assign misaligned    = ((bus.size_i == 2'b01) && lane[0]) ||
                         ((bus.size_i == 2'b10) && (lane != 2'b00));
  assign reserved_size = (bus.size_i == 2'b11);
  assign req_error     = out_of_range || misaligned || reserved_size;

  // Gating with the reset input keeps ready low for the whole reset
  // window and lets it rise as soon as reset is released.
  assign ready     = reset && (state_reg == S_IDLE);
  assign accept    = bus.req_i && ready;
  assign store_ok  = accept && bus.we_i && !req_error;
  assign load_ok   = accept && !bus.we_i && !req_error;
  assign error_acc = accept && req_error;

  // ---------------------------------------------------------------------
  // Per-lane write enables and lane-aligned write data
  // ---------------------------------------------------------------------
  logic [NUM_LANES-1:0]  lane_we;
  logic [DATA_WIDTH-1:0] lane_wdata;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_we[gi] = store_ok && (
        ((bus.size_i == 2'b00) && (lane == 2'(gi))) ||
        ((bus.size_i == 2'b01) && (lane[1] == 1'(gi / 2))) ||
        (bus.size_i == 2'b10));

      // Sub-word data is replicated so every candidate lane sees it.
      assign lane_wdata[gi*8 +: 8] =
        (bus.size_i == 2'b10) ? bus.write_data_i[gi*8 +: 8] :
        (bus.size_i == 2'b01) ? bus.write_data_i[(gi % 2)*8 +: 8] :
                                bus.write_data_i[7:0];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // RAM: byte-enabled write, registered read on load acceptance
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_we[i]) begin
        mem[word_idx][i*8 +: 8] <= lane_wdata[i*8 +: 8];
      end
    end
    if (load_ok) begin
      rd_word_reg     <= mem[word_idx];
      rd_lane_reg     <= lane;
      rd_size_reg     <= bus.size_i;
      rd_unsigned_reg <= bus.unsigned_i;
    end
  end

  // ---------------------------------------------------------------------
  // Load data extraction and extension
  // ---------------------------------------------------------------------
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [DATA_WIDTH-1:0] fmt_value;

  always_comb begin
    byte_val  = rd_word_reg[{rd_lane_reg, 3'b000} +: 8];
    half_val  = rd_lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
    fmt_value = rd_word_reg;
    case (rd_size_reg)
      2'b00:   fmt_value = {{24{~rd_unsigned_reg & byte_val[7]}}, byte_val};
      2'b01:   fmt_value = {{16{~rd_unsigned_reg & half_val[15]}}, half_val};
      default: fmt_value = rd_word_reg;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // show_reg marks the cycle of a load response, where data_o is taken
  // straight from the extraction logic; on the following edge that value
  // is frozen into hold_reg so data_o stays stable even if a new load
  // overwrites the read registers before its own response.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    valid_next = 1'b0;
    error_next = 1'b0;
    hold_next  = show_reg ? fmt_value : hold_reg;
    show_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (error_acc) begin
          valid_next = 1'b1;
          error_next = 1'b1;
          hold_next  = '0;
        end else if (store_ok) begin
          valid_next = 1'b1;
          hold_next  = '0;
        end else if (load_ok) begin
          if (READ_LATENCY <= 1) begin
            valid_next = 1'b1;
            show_next  = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 2'd0) begin
          state_next = S_IDLE;
          valid_next = 1'b1;
          show_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 2'd0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
      hold_reg  <= '0;
      show_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      error_reg <= error_next;
      hold_reg  <= hold_next;
      show_reg  <= show_next;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_reg;
  assign bus.error_o = error_reg;
  assign bus.data_o  = show_reg ? fmt_value : hold_reg;

endmodule
